// File: rtl/pet2001_video_pkg.sv
// pet2001_video_pkg
//   Shared constants and types for the PET 2001 video pixel back end.
//   CELL_PIX    : pixels serialised per 1 us character cell
//   PIX_DELAY   : strobe/pixel pipeline latency in 8 MHz pixel ticks
//   crom_addr_t : character ROM address {gfx, code[6:0], ra[2:0]}
//   strobes_t   : timing-generator strobes that travel alongside the pixels
package pet2001_video_pkg;

  localparam int CELL_PIX  = 8;
  localparam int PIX_DELAY = 8;

  typedef logic [10:0] crom_addr_t;

  typedef struct packed {
    logic de;
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } strobes_t;

  // Glyph-row address: bank select on top, 7-bit character code, then row.
  function automatic crom_addr_t make_crom_addr(input logic       gfx,
                                                input logic [6:0] code,
                                                input logic [2:0] ra);
    return {gfx, code, ra};
  endfunction

endpackage

// File: rtl/pet2001_pixel_shifter_if.sv
// pet2001_pixel_shifter_if
//   Memory-side bus of the pixel shifter: video RAM and character ROM reads.
//   vram_addr (11) / vram_data (8) : video RAM read port
//   crom_addr (11) / crom_data (8) : character ROM read port
//   modport master : the pixel shifter (drives addresses, receives data)
//   modport slave  : the memories (receive addresses, drive data)
//
// Bus protocol: there is no valid/ready pair. Both ports are fixed-latency
// synchronous reads -- an address held stable on a clk edge yields its data
// on the following clk edge. The shifter keeps each address stable for a
// whole pixel tick, so a read is never lost or back-pressured.
interface pet2001_pixel_shifter_if;
  import pet2001_video_pkg::*;

  logic [10:0] vram_addr;
  logic [7:0]  vram_data;
  crom_addr_t  crom_addr;
  logic [7:0]  crom_data;

  modport master (
    output vram_addr,
    input  vram_data,
    output crom_addr,
    input  crom_data
  );

  modport slave (
    input  vram_addr,
    output vram_data,
    input  crom_addr,
    output crom_data
  );

endinterface

// File: rtl/pet2001_strobe_delay.sv
// pet2001_strobe_delay
//   DELAY-deep shift register of timing strobes, advanced on ce.
//   clk     : system clock
//   reset_n : synchronous active-low reset, clears every stage
//   ce      : shift enable (8 MHz pixel tick)
//   din     : strobes entering the line
//   dout    : strobes leaving the line, DELAY ce ticks after entry
module pet2001_strobe_delay
  import pet2001_video_pkg::*;
#(
  parameter int DELAY = PIX_DELAY
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     ce,
  input  strobes_t din,
  output strobes_t dout
);

  strobes_t stage [DELAY];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DELAY; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= din;
      for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DELAY-1];

endmodule

// File: rtl/pet2001_pixel_shifter.sv
// pet2001_pixel_shifter
//   PET 2001 pixel back end: fetches the character code from video RAM,
//   looks up the glyph row in character ROM, applies reverse video and
//   blanking, and serialises 8 pixels per character cell. Timing strobes
//   are delayed so they stay aligned with the serial pixel stream.
//   clk, reset_n     : system clock, synchronous active-low reset
//   ce_8mp           : generator tick; phase counter advances here
//   ce_8mn           : pixel tick (>=3 clk after ce_8mp); pipeline advances
//   vid_ma, vid_ra   : matrix / row address from the timing generator
//   vid_de, vid_*    : display enable, blank and sync strobes
//   video_blank      : forces pixels to 0 from the next cell boundary
//   video_gfx        : character ROM bank select
//   mem              : video RAM / character ROM read bus (master side)
//   pix              : serial pixel, leftmost first
//   de_o .. vsync_o  : strobes aligned with pix
//   dbg_ph           : phase counter, observable for checkers
module pet2001_pixel_shifter
  import pet2001_video_pkg::*;
#(
  parameter int DELAY = PIX_DELAY
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_8mp,
  input  logic        ce_8mn,
  input  logic [13:0] vid_ma,
  input  logic [4:0]  vid_ra,
  input  logic        vid_de,
  input  logic        vid_hblank,
  input  logic        vid_vblank,
  input  logic        vid_hsync,
  input  logic        vid_vsync,
  input  logic        video_blank,
  input  logic        video_gfx,
  pet2001_pixel_shifter_if.master mem,
  output logic        pix,
  output logic        de_o,
  output logic        hblank_o,
  output logic        vblank_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [2:0]  dbg_ph
);

  // Upper matrix-address bits wrap away; only row bits [2:0] select a row.
  logic unused_bits;
  assign unused_bits = &{1'b0, vid_ma[13:11], vid_ra[4:3]};

  // ---------------------------------------------------------------------
  // Phase counter: mirrors the generator's hc[2:0]. The generator's hblank
  // falls as hc moves onto the last pixel of the line, so the fall is seen
  // one ce_8mp later, exactly when hc wraps to a cell start.
  // ---------------------------------------------------------------------
  logic [2:0] ph;
  logic       hb_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ph   <= '0;
      hb_q <= 1'b0;
    end else if (ce_8mp) begin
      hb_q <= vid_hblank;
      if (hb_q && !vid_hblank) ph <= '0;
      else                     ph <= ph + 3'd1;
    end
  end

  assign dbg_ph = ph;

  // ---------------------------------------------------------------------
  // Cell pipeline on ce_8mn.
  //   ph==0 : latch matrix/row address; load shifter with previous cell
  //   ph==1 : code from video RAM is back; issue character ROM address
  //   else  : shift one pixel out
  // The load term reads inv_q/de_q/crom_data before the ph==1 overwrite,
  // so a cell's glyph is displayed during the following cell period.
  // ---------------------------------------------------------------------
  logic [10:0] vram_addr_q;
  crom_addr_t  crom_addr_q;
  logic [2:0]  ra_q;
  logic        inv_q;
  logic        de_q;
  logic [7:0]  shifter;
  logic [7:0]  glyph_load;

  // Reverse video only inside the display area; borders and blank stay 0.
  assign glyph_load = (mem.crom_data ^ {CELL_PIX{inv_q}}) &
                      {CELL_PIX{de_q & ~video_blank}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vram_addr_q <= '0;
      crom_addr_q <= '0;
      ra_q        <= '0;
      inv_q       <= 1'b0;
      de_q        <= 1'b0;
      shifter     <= '0;
    end else if (ce_8mn) begin
      if (ph == 3'd0) begin
        vram_addr_q <= vid_ma[10:0];
        ra_q        <= vid_ra[2:0];
        shifter     <= glyph_load;
      end else begin
        shifter     <= {shifter[6:0], 1'b0};
      end
      if (ph == 3'd1) begin
        inv_q       <= mem.vram_data[7];
        crom_addr_q <= make_crom_addr(video_gfx, mem.vram_data[6:0], ra_q);
        de_q        <= vid_de;
      end
    end
  end

  assign mem.vram_addr = vram_addr_q;
  assign mem.crom_addr = crom_addr_q;
  assign pix           = shifter[7];

  // ---------------------------------------------------------------------
  // Strobe alignment. Strobes are captured on the same ce_8mn edges the
  // pipeline samples the generator, then travel DELAY ticks; they leave on
  // the edge that loads the matching cell into the shifter.
  // ---------------------------------------------------------------------
  strobes_t strb_in;
  strobes_t strb_q;
  strobes_t strb_out;

  assign strb_in = '{de: vid_de, hblank: vid_hblank, vblank: vid_vblank,
                     hsync: vid_hsync, vsync: vid_vsync};

  always_ff @(posedge clk) begin
    if (!reset_n)    strb_q <= '0;
    else if (ce_8mn) strb_q <= strb_in;
  end

  pet2001_strobe_delay #(.DELAY(DELAY)) u_strobe_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce_8mn),
    .din     (strb_q),
    .dout    (strb_out)
  );

  assign de_o     = strb_out.de;
  assign hblank_o = strb_out.hblank;
  assign vblank_o = strb_out.vblank;
  assign hsync_o  = strb_out.hsync;
  assign vsync_o  = strb_out.vsync;

endmodule

// File: tb/tb_pet2001_pixel_shifter.sv
module tb_pet2001_pixel_shifter;
  import pet2001_video_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ce_8mp, ce_8mn;
  logic [13:0] vid_ma;
  logic [4:0]  vid_ra;
  logic        vid_de, vid_hblank, vid_vblank, vid_hsync, vid_vsync;
  logic        video_blank, video_gfx;
  logic        pix, de_o, hblank_o, vblank_o, hsync_o, vsync_o;
  logic [2:0]  dbg_ph;

  pet2001_pixel_shifter_if mem_if ();

  pet2001_pixel_shifter #(.DELAY(PIX_DELAY)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_8mp      (ce_8mp),
    .ce_8mn      (ce_8mn),
    .vid_ma      (vid_ma),
    .vid_ra      (vid_ra),
    .vid_de      (vid_de),
    .vid_hblank  (vid_hblank),
    .vid_vblank  (vid_vblank),
    .vid_hsync   (vid_hsync),
    .vid_vsync   (vid_vsync),
    .video_blank (video_blank),
    .video_gfx   (video_gfx),
    .mem         (mem_if.master),
    .pix         (pix),
    .de_o        (de_o),
    .hblank_o    (hblank_o),
    .vblank_o    (vblank_o),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .dbg_ph      (dbg_ph)
  );

  // ---------------- memory models (1 clk read latency) ----------------
  logic [7:0] vram_mem [2048];
  logic [7:0] crom_mem [2048];

  always @(posedge clk) begin
    mem_if.vram_data <= vram_mem[mem_if.vram_addr];
    mem_if.crom_data <= crom_mem[mem_if.crom_addr];
  end

  // ---------------- counters / scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [0:0] exp_q  [$];   // expected serial pixels
  logic [4:0] strb_q [$];   // expected strobes {de,hblank,vblank,hsync,vsync}

  always @(posedge clk) begin
    assert (!(ce_8mp === 1'b1 && ce_8mn === 1'b1)) else begin
      miscompares++;
      $error("FAIL ce_overlap observed=1 expected=0");
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- timing generator model ----------------
  int          hc;
  int          ticks;
  bit          synced;
  logic [13:0] line_base;
  logic [2:0]  line_ra;
  logic        gen_vblank, gen_vsync;

  // pending cell (fetched, not yet displayed)
  bit          pend_valid;
  logic [7:0]  pend_glyph;
  logic        pend_inv, pend_de;
  logic [10:0] exp_vaddr;
  logic [10:0] exp_caddr;

  // 64 hc per line: display hc 0..39, hblank 55..62, hsync 57..59
  task automatic gen_drive();
    logic [13:0] ma;
    ma         = line_base + 14'(hc / 8);
    vid_ma     = ma;
    vid_ra     = {2'b10, line_ra};
    vid_de     = (hc < 40);
    vid_hblank = (hc >= 55 && hc <= 62);
    vid_hsync  = (hc >= 57 && hc <= 59);
    vid_vblank = gen_vblank;
    vid_vsync  = gen_vsync;
  endtask

  // One 8 MHz period: ce_8mp, three clk later ce_8mn, then sampling.
  task automatic tick();
    logic [7:0] code;
    logic [7:0] pv;
    logic [0:0] ep;
    logic [4:0] es;
    @(negedge clk) ce_8mp = 1'b1;
    @(negedge clk) ce_8mp = 1'b0;
    ticks++;
    hc = (hc + 1) % 64;
    gen_drive();
    if (hc == 0) synced = 1'b1;
    check("ph", 16'(dbg_ph), synced ? 16'(hc % 8) : 16'(ticks % 8));
    if (synced && (hc % 8) == 0) begin
      if (pend_valid) begin
        pv = (pend_glyph ^ {8{pend_inv}}) & {8{pend_de & ~video_blank}};
        for (int b = 7; b >= 0; b--) exp_q.push_back(pv[b]);
      end
      code       = vram_mem[vid_ma[10:0]];
      exp_vaddr  = vid_ma[10:0];
      exp_caddr  = {video_gfx, code[6:0], vid_ra[2:0]};
      pend_glyph = crom_mem[exp_caddr];
      pend_inv   = code[7];
      pend_de    = vid_de;
      pend_valid = 1'b1;
    end
    strb_q.push_back({vid_de, vid_hblank, vid_vblank, vid_hsync, vid_vsync});
    @(negedge clk);
    @(negedge clk) ce_8mn = 1'b1;
    @(negedge clk) ce_8mn = 1'b0;
    if (exp_q.size() > 0) begin
      ep = exp_q.pop_front();
      check("pix", 16'(pix), 16'(ep));
    end
    es = strb_q.pop_front();
    check("strobes", 16'({de_o, hblank_o, vblank_o, hsync_o, vsync_o}), 16'(es));
    if (synced && (hc % 8) == 0) check("vram_addr", 16'(mem_if.vram_addr), 16'(exp_vaddr));
    if (synced && (hc % 8) == 1) check("crom_addr", 16'(mem_if.crom_addr), 16'(exp_caddr));
    @(negedge clk);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (hc == target) break;
    end
  endtask

  task automatic set_line(input logic [13:0] base, input logic [2:0] ra, input logic gfx);
    line_base = base;
    line_ra   = ra;
    video_gfx = gfx;
  endtask

  // Reset held 20 clk with strobes and enables toggling; outputs must be 0.
  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ce_8mp     = (i % 4 == 0);
      ce_8mn     = (i % 4 == 2);
      vid_ma     = 14'($urandom_range(1, 16383));
      vid_ra     = 5'($urandom_range(0, 31));
      vid_de     = 1'($urandom_range(0, 1));
      vid_hblank = ~vid_hblank;
      vid_vblank = 1'($urandom_range(0, 1));
      vid_hsync  = ~vid_hsync;
      vid_vsync  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_pix", 16'(pix), 16'h0);
      check("rst_strobes", 16'({de_o, hblank_o, vblank_o, hsync_o, vsync_o}), 16'h0);
      check("rst_vram_addr", 16'(mem_if.vram_addr), 16'h0);
      check("rst_crom_addr", 16'(mem_if.crom_addr), 16'h0);
      check("rst_ph", 16'(dbg_ph), 16'h0);
    end
    ce_8mp  = 1'b0;
    ce_8mn  = 1'b0;
    reset_n = 1'b1;
    exp_q.delete();
    strb_q.delete();
    for (int i = 0; i < PIX_DELAY; i++) strb_q.push_back(5'd0);
    ticks      = 0;
    synced     = 1'b0;
    pend_valid = 1'b0;
    hc         = 43;
    gen_drive();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n     = 1'b1;
    ce_8mp      = 1'b0;
    ce_8mn      = 1'b0;
    vid_ma      = '0;
    vid_ra      = '0;
    vid_de      = 1'b0;
    vid_hblank  = 1'b0;
    vid_vblank  = 1'b0;
    vid_hsync   = 1'b0;
    vid_vsync   = 1'b0;
    video_blank = 1'b0;
    video_gfx   = 1'b0;
    gen_vblank  = 1'b0;
    gen_vsync   = 1'b0;
    line_base   = 14'h0000;
    line_ra     = 3'd0;
    hc          = 43;
    for (int i = 0; i < 2048; i++) begin
      vram_mem[i] = 8'($urandom_range(0, 255));
      crom_mem[i] = 8'($urandom_range(0, 255));
    end
    // line 1 cells: plain glyph, reverse glyph, reverse in border
    vram_mem[11'h028] = 8'h41;
    vram_mem[11'h029] = 8'hC1;
    vram_mem[11'h02D] = 8'hC1;
    crom_mem[{1'b1, 7'h41, 3'd3}] = 8'hA5;

    do_reset();

    // free-running phase until the first hblank fall, then line 1
    run_until(63);
    set_line(14'h0028, 3'd3, 1'b1);
    run_until(63);

    // line 2: matrix address wraps past 11 bits (0x2FFE.. -> 0x7FE, 0x7FF, 0x000)
    set_line(14'h2FFE, 3'd5, 1'b0);
    run_until(63);

    // line 3: blank mid-cell, vblank and vsync pulses
    set_line(14'h0100, 3'd7, 1'b1);
    run_until(19);
    video_blank = 1'b1;
    gen_vblank  = 1'b1;
    run_until(26);
    gen_vblank  = 1'b0;
    run_until(30);
    gen_vsync   = 1'b1;
    run_until(33);
    gen_vsync   = 1'b0;
    run_until(63);
    video_blank = 1'b0;

    // line 4: normal display again, then reset mid-frame
    set_line(14'h0200, 3'd0, 1'b0);
    run_until(63);
    run_until(10);
    do_reset();
    run_until(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
